// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants, channel state type and period clamp for clk_div_multi
package clk_div_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int MIN_DIV   = 2;

    typedef enum logic {
        CH_STOP = 1'b0,
        CH_RUN  = 1'b1
    } chan_state_t;

    // Periods below two cycles cannot hold both a high and a low phase.
    function automatic int unsigned clamp_div(input int unsigned d);
        return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divided-clock channel with boundary-aligned reconfiguration
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr,
    input  logic [CNT_W-1:0] div,
    input  logic [CNT_W-1:0] phase,
    input  logic             en,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    chan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] stg_div_q, stg_div_d;
    logic             stg_en_q, stg_en_d;
    logic             pend_d, clk_d, tick_d;

    logic [CNT_W-1:0] peff, half, last;
    logic [CNT_W-1:0] new_last, start;

    assign peff     = CNT_W'(clamp_div(32'(div_q)));
    assign half     = peff - (peff >> 1);
    assign last     = peff - CNT_W'(1);
    assign new_last = CNT_W'(clamp_div(32'(div))) - CNT_W'(1);
    assign start    = (phase > new_last) ? new_last : phase;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= CH_RUN;
            cnt_q     <= '0;
            div_q     <= CNT_W'(DEFAULT_DIV);
            stg_div_q <= '0;
            stg_en_q  <= 1'b0;
            pending   <= 1'b0;
            clk_out   <= 1'b0;
            tick      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            stg_div_q <= stg_div_d;
            stg_en_q  <= stg_en_d;
            pending   <= pend_d;
            clk_out   <= clk_d;
            tick      <= tick_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        stg_div_d = stg_div_q;
        stg_en_d  = stg_en_q;
        pend_d    = pending;
        clk_d     = 1'b0;
        tick_d    = 1'b0;
        case (state_q)
            CH_RUN: begin
                clk_d  = (cnt_q < half);
                tick_d = (cnt_q == '0);
                if (cnt_q == last) begin
                    cnt_d  = '0;
                    pend_d = 1'b0;
                    // A write landing on the boundary wins over anything staged.
                    if (wr || pending) begin
                        div_d = wr ? div : stg_div_q;
                        if (!(wr ? en : stg_en_q)) begin
                            state_d = CH_STOP;
                            clk_d   = 1'b0;
                            tick_d  = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (wr) begin
                        stg_div_d = div;
                        stg_en_d  = en;
                        pend_d    = 1'b1;
                    end
                end
            end
            default: begin
                if (wr) begin
                    div_d = div;
                    if (en) begin
                        state_d = CH_RUN;
                        cnt_d   = start;
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - NUM_CH independent run-time configurable clock dividers
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = 2,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_phase,
    input  logic              cfg_en,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        // Out-of-range channel numbers match no instance and are dropped.
        assign sel = cfg_wr && (32'(cfg_ch) == 32'(i));

        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clock   (clock),
            .reset   (reset),
            .wr      (sel),
            .div     (cfg_div),
            .phase   (cfg_phase),
            .en      (cfg_en),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pending (pending[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - randomized bench for clk_div_multi against a period-level reference model
module tb_clk_div_multi;

    localparam int NUM_CH = 5;
    localparam int CNT_W  = 8;
    localparam int DEF    = 2;
    localparam int CH_W   = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              cfg_wr;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [CNT_W-1:0]  cfg_phase;
    logic              cfg_en;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;

    int n_chk  = 0;
    int n_fail = 0;

    int          m_per [NUM_CH];
    int          m_pos [NUM_CH];
    bit          m_run [NUM_CH];
    bit          m_pend[NUM_CH];
    int          m_sdiv[NUM_CH];
    bit          m_sen [NUM_CH];
    logic [NUM_CH-1:0] e_clk, e_tick, e_pend;

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cfg_wr    (cfg_wr),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .cfg_en    (cfg_en),
        .clk_out   (clk_out),
        .tick      (tick),
        .pending   (pending)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    // Reference: each running channel sits at a position within its period;
    // high for the first ceil(P/2) positions, tick at position 0.
    task automatic model_edge();
        for (int c = 0; c < NUM_CH; c++) begin
            bit wr;
            int p;
            wr = cfg_wr && (int'(cfg_ch) == c);
            if (reset) begin
                m_run[c] = 1; m_per[c] = DEF; m_pos[c] = 0; m_pend[c] = 0;
                e_clk[c] = 0; e_tick[c] = 0;
            end else if (m_run[c]) begin
                p = eff(m_per[c]);
                e_clk[c]  = (m_pos[c] < (p + 1) / 2);
                e_tick[c] = (m_pos[c] == 0);
                if (m_pos[c] == p - 1) begin
                    m_pos[c] = 0;
                    if (wr || m_pend[c]) begin
                        m_per[c] = wr ? int'(cfg_div) : m_sdiv[c];
                        if (!(wr ? cfg_en : m_sen[c])) begin
                            m_run[c] = 0; e_clk[c] = 0; e_tick[c] = 0;
                        end
                    end
                    m_pend[c] = 0;
                end else begin
                    m_pos[c]++;
                    if (wr) begin
                        m_sdiv[c] = int'(cfg_div); m_sen[c] = cfg_en; m_pend[c] = 1;
                    end
                end
            end else begin
                e_clk[c] = 0; e_tick[c] = 0;
                if (wr) begin
                    m_per[c] = int'(cfg_div);
                    if (cfg_en) begin
                        m_run[c] = 1;
                        m_pos[c] = (int'(cfg_phase) < eff(m_per[c]) - 1) ? int'(cfg_phase)
                                                                         : eff(m_per[c]) - 1;
                    end
                end
            end
            e_pend[c] = m_pend[c];
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        check("clk_out", 32'(clk_out), 32'(e_clk));
        check("tick", 32'(tick), 32'(e_tick));
        check("pending", 32'(pending), 32'(e_pend));
    endtask

    task automatic write(input int ch, input int d, input int ph, input bit en);
        cfg_wr = 1'b1; cfg_ch = CH_W'(ch); cfg_div = CNT_W'(d);
        cfg_phase = CNT_W'(ph); cfg_en = en;
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic wait_idle(input int ch);
        int n;
        n = 0;
        while (pending[ch] && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) check("wait_timeout", 32'(1), 32'(0));
    endtask

    initial begin
        reset = 1'b1; cfg_wr = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_phase = '0; cfg_en = 1'b0;
        step();
        step();
        check("rst_clk", 32'(clk_out), 32'(0));
        check("rst_pend", 32'(pending), 32'(0));
        reset = 1'b0;
        step();
        check("first_clk", 32'(clk_out), 32'h1f);
        check("first_tick", 32'(tick), 32'h1f);
        step();
        check("second_clk", 32'(clk_out), 32'h00);
        repeat (6) step();

        write(1, 5, 0, 1);
        wait_idle(1);
        repeat (12) step();

        write(2, 6, 0, 0);
        wait_idle(2);
        repeat (3) step();
        check("stopped_clk2", 32'(clk_out[2]), 32'(0));
        write(2, 6, 4, 1);
        step();
        check("phase_clk2", 32'(clk_out[2]), 32'(0));
        step();
        step();
        check("phase_tick2", 32'(tick[2]), 32'(1));
        repeat (12) step();

        write(0, 8, 0, 1);
        wait_idle(0);
        repeat (3) step();
        write(0, 10, 0, 1);
        write(0, 3, 0, 1);
        wait_idle(0);
        repeat (9) step();

        write(3, 2, 0, 0);
        wait_idle(3);
        for (int i = 0; i < 4; i++) begin
            step();
            check("stop_tick3", 32'(tick[3]), 32'(0));
        end

        write(4, 0, 0, 1);
        repeat (4) step();
        write(4, 1, 0, 1);
        repeat (4) step();
        write(NUM_CH, 7, 3, 0);
        write(7, 9, 0, 0);
        repeat (4) step();

        write(1, 20, 0, 1);
        reset = 1'b1;
        step();
        check("rst_mid_pend", 32'(pending), 32'(0));
        reset = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0) begin
                write($urandom_range(0, 7), $urandom_range(0, 9),
                      $urandom_range(0, 12), $urandom_range(0, 3) != 0);
            end else begin
                step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised successor to the single fixed-ratio divider that derives processor and regfile clocks from the board clock.
- Generates NUM_CH independent divided clock outputs from one source clock, each with a matching one-cycle tick strobe.
- Each channel's divide ratio, start phase and run/stop state are reconfigurable at run time.
- Ratio changes and stops take effect only at a period boundary, so no output ever produces a runt pulse.

Parameters:
- NUM_CH, 4: number of output channels.
- CNT_W, 8: width of divide and phase fields and of each channel counter.
- DEFAULT_DIV, 2: period in source cycles loaded at reset; must be >= 2.

Ports:
- clock  in  1  source clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- cfg_wr  in  1  configuration write strobe, one cycle.
- cfg_ch  in  max(1,$clog2(NUM_CH))  target channel; values >= NUM_CH are ignored.
- cfg_div  in  CNT_W  requested period P in source cycles.
- cfg_phase  in  CNT_W  starting count applied when a channel starts.
- cfg_en  in  1  1 = run, 0 = stop.
- clk_out  out  NUM_CH  divided clocks, registered.
- tick  out  NUM_CH  one-cycle pulse at the start of each period, registered.
- pending  out  NUM_CH  1 while a staged config awaits a period boundary.

Behaviour:
- Reset (sync): every channel running, P=DEFAULT_DIV, cnt=0, clk_out=0, tick=0, pending=0, staged config cleared.
- Reset mid-operation discards all staged writes the same cycle.
- Effective period: Peff = max(cfg_div, 2); cfg_div values 0 and 1 clamp to 2. Arithmetic is unsigned.
- Running channel, at every edge:
  - clk_out <= (cnt < ceil(Peff/2)); tick <= (cnt == 0).
  - cnt <= (cnt == Peff-1) ? 0 : cnt+1.
  - Outputs lag cnt by one register stage.
- Duty cycle: high for ceil(P/2) cycles, low for floor(P/2) cycles. P=5 gives 3 high, 2 low.
- Write to a running channel: {div, en} are staged and pending goes to 1. A second write before the boundary overwrites the staged value.
- Boundary: the edge where cnt == Peff-1.
  - Staged div is loaded and cnt <= 0; pending clears.
  - If the staged en is 0, the channel stops instead: cnt=0, clk_out <= 0, tick <= 0, held there.
- Write to a running channel in the same cycle as its boundary: applied directly at that edge, pending is not set.
- Write with cfg_en=1 to a stopped channel: applied at the next edge.
  - P <= new div; cnt <= min(cfg_phase, Peff-1).
  - Outputs follow from that cnt on the next cycle.
- Write with cfg_en=0 to a stopped channel: div is updated, channel stays stopped.
- cfg_phase is ignored for writes to a running channel; phase only applies at start.
- Channels are fully independent; only the addressed channel's state changes on a write.
- With NUM_CH=1, cfg_ch is 1 bit and value 1 is ignored.

Decomposition:
- Shared package (clk_div_pkg):
  - CNT_W default.
  - Minimum period constant MIN_DIV=2.
  - Clamp function for Peff.
- Sub-module clk_div_chan: one channel with counter, staged register, boundary detect and outputs.
- clk_div_multi handles cfg_ch decode and a generate loop of NUM_CH clk_div_chan instances.

Test Plan:
- Reset, run 8 cycles, no writes → all clk_out toggle every cycle (1,0,1,0…); tick high on every second cycle starting the first cycle after reset deasserts.
- Write ch1 div=5, en=1 while running → pending[1]=1 until the boundary; then clk_out[1] shows 3 high, 2 low with period 5; other channels unchanged.
- Stop ch2, then write div=6, phase=4, en=1 → the cycle after the start edge shows cnt=4, clk_out[2]=0; tick[2] fires 2 cycles later, then period is 6.
- Write ch0 div=10, then div=3 before the boundary → only div=3 is applied; no high or low phase shorter than 1 cycle appears on clk_out[0].
- Write ch3 en=0 mid-period → clk_out[3] completes the current period, then holds 0; tick[3] stays 0.
- Write div=0 and div=1 → behaves as P=2. cfg_ch=NUM_CH → no state change. Assert reset while pending=1 → pending cleared, all channels at defaults next cycle.
